// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types: machine word, redirect source and scheduler buffer state.
package rv32i_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        REDIR_ID = 1'b0,
        REDIR_EX = 1'b1
    } redirect_src_t;

    typedef enum logic {
        SCHED_EMPTY = 1'b0,
        SCHED_FULL  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/redirect_buf.sv
// One-entry redirect holding register: load on grant, empty on drain or flush.
module redirect_buf
    import rv32i_types_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic              drain,
    input  logic              flush,
    input  logic [WIDTH-1:0]  load_addr,
    input  redirect_src_t     load_src,
    input  logic              load_mis,
    output logic              valid,
    output logic [WIDTH-1:0]  addr,
    output redirect_src_t     src,
    output logic              misaligned
);

    sched_state_t state, state_nxt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= SCHED_EMPTY;
        else       state <= state_nxt;
    end

    // Flush beats everything; a load while draining reloads rather than empties.
    always_comb begin
        state_nxt = state;
        if (flush)      state_nxt = SCHED_EMPTY;
        else if (load)  state_nxt = SCHED_FULL;
        else if (drain) state_nxt = SCHED_EMPTY;
    end

    always_comb begin
        valid = (state == SCHED_FULL);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr       <= '0;
            src        <= REDIR_ID;
            misaligned <= 1'b0;
        end else if (load && !flush) begin
            addr       <= load_addr;
            src        <= load_src;
            misaligned <= load_mis;
        end
    end

endmodule

// File: rtl/jump_target_sched.sv
// Arbitrates decode/execute jump target requests, computes base+offset and buffers the redirect.
// Optional performance counters are enabled with `define JUMP_TARGET_SCHED_PERF_EN.
module jump_target_sched
    import rv32i_types_pkg::*;
#(
    parameter int         WIDTH      = WORD_W,
    parameter logic [1:0] ALIGN_MASK = 2'b10
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_req,
    input  logic [WIDTH-1:0]  ex_base,
    input  logic [WIDTH-1:0]  ex_offset,
    input  logic              ex_is_jalr,
    output logic              ex_gnt,
    input  logic              id_req,
    input  logic [WIDTH-1:0]  id_base,
    input  logic [WIDTH-1:0]  id_offset,
    output logic              id_gnt,
    input  logic              flush,
    output logic              redirect_valid,
    output logic [WIDTH-1:0]  redirect_addr,
    output logic              redirect_src,
`ifdef JUMP_TARGET_SCHED_PERF_EN
    output logic [31:0]       perf_redirects,
    output logic [31:0]       perf_stalls,
    output logic [31:0]       perf_overwrites,
`endif
    output logic              redirect_misaligned,
    input  logic              redirect_ready
);

    logic             drain, buf_free, hold_id, overwrite, load;
    logic [WIDTH-1:0] op_a, op_b, sum, tgt;
    logic             tgt_mis;
    redirect_src_t    buf_src, load_src;

    assign drain    = redirect_valid & redirect_ready;
    assign buf_free = ~redirect_valid | drain;
    assign hold_id  = redirect_valid & (buf_src == REDIR_ID);

    // Execute squashes a younger buffered decode redirect; decode never displaces anything.
    assign ex_gnt    = ~flush & ex_req & (buf_free | hold_id);
    assign id_gnt    = ~flush & id_req & ~ex_req & buf_free;
    assign overwrite = ex_gnt & hold_id & ~drain;
    assign load      = ex_gnt | id_gnt;
    assign load_src  = ex_gnt ? REDIR_EX : REDIR_ID;

    // Single shared adder; execute owns it whenever it is requesting.
    assign op_a    = ex_req ? ex_base   : id_base;
    assign op_b    = ex_req ? ex_offset : id_offset;
    assign sum     = op_a + op_b;
    assign tgt     = {sum[WIDTH-1:1], sum[0] & ~(ex_req & ex_is_jalr)};
    assign tgt_mis = |(tgt[1:0] & ALIGN_MASK);

    redirect_buf #(.WIDTH(WIDTH)) u_buf (
        .CLK        (CLK),
        .nRST       (nRST),
        .load       (load),
        .drain      (drain),
        .flush      (flush),
        .load_addr  (tgt),
        .load_src   (load_src),
        .load_mis   (tgt_mis),
        .valid      (redirect_valid),
        .addr       (redirect_addr),
        .src        (buf_src),
        .misaligned (redirect_misaligned)
    );

    assign redirect_src = (buf_src == REDIR_EX);

`ifdef JUMP_TARGET_SCHED_PERF_EN
    logic stall;
    assign stall = (ex_req & ~ex_gnt) | (id_req & ~id_gnt);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_redirects  <= '0;
            perf_stalls     <= '0;
            perf_overwrites <= '0;
        end else begin
            if (drain)     perf_redirects  <= perf_redirects + 32'd1;
            if (stall)     perf_stalls     <= perf_stalls + 32'd1;
            if (overwrite) perf_overwrites <= perf_overwrites + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jump_target_sched.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_jump_target_sched;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ex_req, ex_is_jalr, id_req, flush, redirect_ready;
    logic [31:0] ex_base, ex_offset, id_base, id_offset;
    logic        ex_gnt, id_gnt, redirect_valid, redirect_src, redirect_misaligned;
    logic [31:0] redirect_addr;
`ifdef JUMP_TARGET_SCHED_PERF_EN
    logic [31:0] perf_redirects, perf_stalls, perf_overwrites;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    jump_target_sched dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .ex_req              (ex_req),
        .ex_base             (ex_base),
        .ex_offset           (ex_offset),
        .ex_is_jalr          (ex_is_jalr),
        .ex_gnt              (ex_gnt),
        .id_req              (id_req),
        .id_base             (id_base),
        .id_offset           (id_offset),
        .id_gnt              (id_gnt),
        .flush               (flush),
        .redirect_valid      (redirect_valid),
        .redirect_addr       (redirect_addr),
        .redirect_src        (redirect_src),
`ifdef JUMP_TARGET_SCHED_PERF_EN
        .perf_redirects      (perf_redirects),
        .perf_stalls         (perf_stalls),
        .perf_overwrites     (perf_overwrites),
`endif
        .redirect_misaligned (redirect_misaligned),
        .redirect_ready      (redirect_ready)
    );

    task automatic idle();
        ex_req = 0; id_req = 0; flush = 0; ex_is_jalr = 0;
        ex_base = 0; ex_offset = 0; id_base = 0; id_offset = 0;
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        idle(); redirect_ready = 0; nRST = 0;
        #2;
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", redirect_valid); end
        checks++; if (redirect_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", redirect_addr); end
        checks++; if (redirect_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %b exp 0", redirect_src); end
        checks++; if (redirect_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b exp 0", redirect_misaligned); end
        tick(); nRST = 1; tick();
    endtask

    task automatic test_id_basic();
        idle(); redirect_ready = 1;
        id_req = 1; id_base = 32'h0000_1000; id_offset = 32'h0000_0020; #1;
        checks++; if (id_gnt !== 1'b1) begin errors++; $display("FAIL id_gnt: got %b exp 1", id_gnt); end
        checks++; if (ex_gnt !== 1'b0) begin errors++; $display("FAIL id_ex_gnt: got %b exp 0", ex_gnt); end
        tick(); id_req = 0;
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL id_valid: got %b exp 1", redirect_valid); end
        checks++; if (redirect_addr !== 32'h0000_1020) begin errors++; $display("FAIL id_addr: got %h exp 00001020", redirect_addr); end
        checks++; if (redirect_src !== 1'b0) begin errors++; $display("FAIL id_src: got %b exp 0", redirect_src); end
        checks++; if (redirect_misaligned !== 1'b0) begin errors++; $display("FAIL id_mis: got %b exp 0", redirect_misaligned); end
        tick();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL id_drain: got %b exp 0", redirect_valid); end
    endtask

    task automatic test_ex_priority();
        idle(); redirect_ready = 1;
        ex_req = 1; ex_base = 32'h8000_0001; ex_offset = 32'h4; ex_is_jalr = 1;
        id_req = 1; id_base = 32'h0000_4000; id_offset = 32'h8; #1;
        checks++; if (ex_gnt !== 1'b1) begin errors++; $display("FAIL prio_ex_gnt: got %b exp 1", ex_gnt); end
        checks++; if (id_gnt !== 1'b0) begin errors++; $display("FAIL prio_id_gnt: got %b exp 0", id_gnt); end
        tick(); idle();
        checks++; if (redirect_addr !== 32'h8000_0004) begin errors++; $display("FAIL prio_addr: got %h exp 80000004", redirect_addr); end
        checks++; if (redirect_src !== 1'b1) begin errors++; $display("FAIL prio_src: got %b exp 1", redirect_src); end
        checks++; if (redirect_misaligned !== 1'b0) begin errors++; $display("FAIL prio_mis: got %b exp 0", redirect_misaligned); end
        tick();
    endtask

    task automatic test_wrap_misalign();
        idle(); redirect_ready = 1;
        ex_req = 1; ex_base = 32'hFFFF_FFF0; ex_offset = 32'h12; ex_is_jalr = 0;
        tick(); idle();
        checks++; if (redirect_addr !== 32'h0000_0002) begin errors++; $display("FAIL wrap_addr: got %h exp 00000002", redirect_addr); end
        checks++; if (redirect_misaligned !== 1'b1) begin errors++; $display("FAIL wrap_mis: got %b exp 1", redirect_misaligned); end
        tick();
    endtask

    task automatic test_overwrite_stall();
        idle(); redirect_ready = 0;
        id_req = 1; id_base = 32'h2000; id_offset = 32'h8;
        tick(); idle();
        checks++; if (redirect_addr !== 32'h2008 || redirect_src !== 1'b0) begin errors++; $display("FAIL ovw_id_load: got %h/%b exp 00002008/0", redirect_addr, redirect_src); end
        ex_req = 1; ex_base = 32'h3000; ex_offset = 32'h10; #1;
        checks++; if (ex_gnt !== 1'b1) begin errors++; $display("FAIL ovw_ex_gnt: got %b exp 1", ex_gnt); end
        tick();
        checks++; if (redirect_addr !== 32'h3010 || redirect_src !== 1'b1 || redirect_valid !== 1'b1) begin errors++; $display("FAIL ovw_result: got %h/%b/%b exp 00003010/1/1", redirect_addr, redirect_src, redirect_valid); end
        ex_base = 32'h4000; #1;
        checks++; if (ex_gnt !== 1'b0) begin errors++; $display("FAIL stall_ex_gnt: got %b exp 0", ex_gnt); end
        tick();
        checks++; if (redirect_addr !== 32'h3010) begin errors++; $display("FAIL stall_hold: got %h exp 00003010", redirect_addr); end
        idle(); redirect_ready = 1; tick();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b exp 0", redirect_valid); end
    endtask

    task automatic test_flush();
        idle(); redirect_ready = 0;
        ex_req = 1; ex_base = 32'h5000; ex_offset = 32'h0;
        tick(); idle();
        flush = 1; id_req = 1; id_base = 32'h6000; #1;
        checks++; if (id_gnt !== 1'b0 || ex_gnt !== 1'b0) begin errors++; $display("FAIL flush_gnt: got %b/%b exp 0/0", id_gnt, ex_gnt); end
        tick(); idle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", redirect_valid); end
    endtask

    task automatic test_reset_mid();
        idle(); redirect_ready = 0;
        ex_req = 1; ex_base = 32'h7000_0000; ex_offset = 32'h6; ex_is_jalr = 0;
        tick(); idle();
        #2 nRST = 0; #1;
        checks++; if ({redirect_valid, redirect_addr, redirect_src, redirect_misaligned} !== 35'h0) begin errors++; $display("FAIL rstmid_outputs: got %b/%h/%b/%b exp all 0", redirect_valid, redirect_addr, redirect_src, redirect_misaligned); end
        #3 nRST = 1;
        tick();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %b exp 0", redirect_valid); end
    endtask

    task automatic test_random();
        bit        m_valid = 0, m_src = 0, m_mis = 0;
        bit [31:0] m_addr = 0;
        longint    m_drains = 0;
        bit        e_ex, e_id, free;
        bit [31:0] t;
        longint    full_sum;
        idle(); redirect_ready = 0; tick();
        m_valid = redirect_valid;
        for (int i = 0; i < 400; i++) begin
            ex_req = ($urandom_range(0, 2) == 0);
            id_req = ($urandom_range(0, 1) == 0);
            ex_base = $urandom; ex_offset = $urandom; ex_is_jalr = $urandom_range(0, 1);
            id_base = $urandom; id_offset = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            redirect_ready = ($urandom_range(0, 2) != 0);
            #1;
            free = !m_valid || redirect_ready;
            e_ex = !flush && ex_req && (free || (m_valid && !m_src));
            e_id = !flush && id_req && !ex_req && free;
            checks++; if (ex_gnt !== e_ex || id_gnt !== e_id) begin errors++; $display("FAIL rand_gnt[%0d]: got %b%b exp %b%b", i, ex_gnt, id_gnt, e_ex, e_id); end
            if (m_valid && redirect_ready) m_drains++;
            if (flush) m_valid = 0;
            else if (e_ex || e_id) begin
                full_sum = e_ex ? (longint'(ex_base) + longint'(ex_offset)) : (longint'(id_base) + longint'(id_offset));
                t = 32'(full_sum % 64'h1_0000_0000);
                if (e_ex && ex_is_jalr) t = t - (t % 2);
                m_valid = 1; m_addr = t; m_src = e_ex; m_mis = ((t / 2) % 2) == 1;
            end else if (m_valid && redirect_ready) m_valid = 0;
            tick();
            checks++; if (redirect_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b exp %b", i, redirect_valid, m_valid); end
            if (m_valid) begin
                checks++;
                if (redirect_addr !== m_addr || redirect_src !== m_src || redirect_misaligned !== m_mis) begin
                    errors++; $display("FAIL rand_data[%0d]: got %h/%b/%b exp %h/%b/%b", i, redirect_addr, redirect_src, redirect_misaligned, m_addr, m_src, m_mis);
                end
            end
        end
`ifdef JUMP_TARGET_SCHED_PERF_EN
        checks++; if (perf_redirects < 32'(m_drains)) begin errors++; $display("FAIL perf_redirects: got %0d exp >= %0d", perf_redirects, m_drains); end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_id_basic();
        test_ex_priority();
        test_wrap_misalign();
        test_overwrite_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jump_target_sched.md
Name: jump_target_sched

Overview:
- Schedules branch/jump target computation between two requesters: decode (JAL, early redirect) and execute (JALR / taken branch).
- Performs the base+offset target add for the winning request.
- Holds the resulting redirect in a one-entry buffer until fetch accepts it.
- Sits between the decode/execute stages and the fetch-stage PC mux.

Parameters:
- WIDTH, 32, address/operand width (word_t width).
- ALIGN_MASK, 2'b10, target bits that flag misalignment when set (no compressed ISA).

Ports:
- CLK  in  1  core clock
- nRST  in  1  asynchronous active-low reset
- ex_req  in  1  execute-stage target request
- ex_base  in  WIDTH  execute base (rs1 or PC)
- ex_offset  in  WIDTH  execute sign-extended immediate
- ex_is_jalr  in  1  clear bit 0 of the target
- ex_gnt  out  1  execute request accepted this cycle
- id_req  in  1  decode-stage JAL request
- id_base  in  WIDTH  decode PC
- id_offset  in  WIDTH  decode J-immediate
- id_gnt  out  1  decode request accepted this cycle
- flush  in  1  pipeline flush (trap/exception)
- redirect_valid  out  1  buffered redirect present
- redirect_addr  out  WIDTH  target address
- redirect_src  out  1  0 = decode, 1 = execute
- redirect_misaligned  out  1  (target & ALIGN_MASK) != 0
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (async, nRST=0): redirect_valid=0, redirect_addr=0, redirect_src=0, redirect_misaligned=0, buffer state EMPTY, counters cleared.
- Target arithmetic:
  - sum = base + offset, modulo 2^WIDTH; carry is discarded.
  - If src=ex and ex_is_jalr, bit 0 is forced to 0.
  - misaligned is computed after masking.
- Buffer states:
  - EMPTY: redirect_valid=0.
  - FULL: redirect_valid=1; outputs are stable until accepted.
- Drain condition: drain = redirect_valid & redirect_ready. A buffer that drains this cycle counts as free for grants this cycle.
- Grants (combinational, same cycle as req):
  - flush=1 → ex_gnt=id_gnt=0.
  - Otherwise, ex_req with buffer free → ex_gnt=1.
  - Otherwise, ex_req with buffer FULL holding src=0 (decode) → ex_gnt=1; the decode redirect is overwritten, because an execute redirect squashes the younger decode one.
  - Otherwise, ex_req with buffer FULL holding src=1 → ex_gnt=0 (stall).
  - id_gnt=1 only if id_req, !ex_req, !flush, and the buffer is free.
  - ex_req and id_req in the same cycle → execute wins; id_gnt=0.
- Latency: a grant in cycle N makes redirect_valid visible in cycle N+1 (registered). Registered fields: addr, src, misaligned.
- Transitions:
  - EMPTY→FULL on any grant.
  - FULL→EMPTY on drain with no grant.
  - FULL→FULL (reload) on drain+grant or on execute-over-decode overwrite.
- flush: state → EMPTY next cycle, regardless of redirect_ready. A flush while FULL discards the redirect.
- redirect_ready while EMPTY is ignored.

Optional Feature:
- Macro: JUMP_TARGET_SCHED_PERF_EN.
- When defined, adds outputs perf_redirects (32), perf_stalls (32), perf_overwrites (32). All reset to 0 and wrap at 2^32.
  - perf_redirects increments on drain.
  - perf_stalls increments per cycle with ex_req&!ex_gnt or id_req&!id_gnt (at most +1 per cycle).
  - perf_overwrites increments on execute-over-decode overwrite.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- rv32i_types_pkg: word_t.
- Add to rv32i_types_pkg:
  - redirect_src_t enum {REDIR_ID=0, REDIR_EX=1}.
  - sched_state_t enum {SCHED_EMPTY, SCHED_FULL}.
- One sub-module, redirect_buf: the one-entry holding register with load/drain/flush. The top contains the grant logic and the adder.

Test Plan:
- Reset mid-operation: nRST low while FULL → all outputs 0 immediately (async); EMPTY after release.
- id_req, base=0x0000_1000, offset=0x0000_0020, ready=1 → id_gnt=1; next cycle valid=1, addr=0x0000_1020, src=0, misaligned=0; then EMPTY.
- ex_req+id_req together, ex base=0x8000_0001, offset=0x4, is_jalr=1 → ex_gnt=1, id_gnt=0; next cycle addr=0x8000_0004, src=1.
- Wrap and misalign: ex base=0xFFFF_FFF0, offset=0x12, is_jalr=0 → addr=0x0000_0002, misaligned=1.
- Overwrite and stall:
  - Decode redirect FULL, ready=0, then ex_req → ex_gnt=1, next addr/src reflect execute.
  - A second ex_req while still not ready → ex_gnt=0.
- Flush while FULL with ready=0 → next cycle valid=0; simultaneous id_req gets id_gnt=0.
